// File: rtl/processor.sv
// Five-stage RV32I-subset pipeline (IF/ID/EX/MEM/WB) with forwarding,
// load-use stall, MEM-stage branch resolution, fixed program ROM and byte data memory.

module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rs1_data_c,
  output logic [31:0] rs2_data_c
);
  localparam int unsigned NREG = 32;

  logic [31:0] registers [0:NREG-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) registers[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      registers[wr_addr] <= wr_data;
    end
  end

  // Same-cycle WB write is visible to the ID read
  always_comb begin
    rs1_data_c = registers[rs1_addr];
    rs2_data_c = registers[rs2_addr];
    if (wr_en && wr_addr != 5'd0 && wr_addr == rs1_addr) rs1_data_c = wr_data;
    if (wr_en && wr_addr != 5'd0 && wr_addr == rs2_addr) rs2_data_c = wr_data;
    if (rs1_addr == 5'd0) rs1_data_c = '0;
    if (rs2_addr == 5'd0) rs2_data_c = '0;
  end
endmodule

module data_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  word_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data_c
);
  localparam int unsigned NBYTE = 256;

  logic [7:0] mem [0:NBYTE-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NBYTE; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[{word_addr, 2'd0}] <= wr_data[7:0];
      mem[{word_addr, 2'd1}] <= wr_data[15:8];
      mem[{word_addr, 2'd2}] <= wr_data[23:16];
      mem[{word_addr, 2'd3}] <= wr_data[31:24];
    end
  end

  assign rd_data_c = {mem[{word_addr, 2'd3}], mem[{word_addr, 2'd2}],
                      mem[{word_addr, 2'd1}], mem[{word_addr, 2'd0}]};
endmodule

module processor (
  input logic clk,
  input logic rst
);
  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [3:0]  ALU_AND   = 4'b0000;
  localparam logic [3:0]  ALU_OR    = 4'b0001;
  localparam logic [3:0]  ALU_ADD   = 4'b0010;
  localparam logic [3:0]  ALU_SUB   = 4'b0110;
  localparam logic [3:0]  ALU_SLT   = 4'b0111;

  logic [XLEN-1:0] pc_current, pc_next, instr_c;

  logic [XLEN-1:0] IF_ID_instr, IF_ID_pc;
  logic            IF_ID_valid;

  logic            ID_EX_valid, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite;
  logic            ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_Branch;
  logic [3:0]      ID_EX_ALUOp;
  logic [2:0]      ID_EX_funct3;
  logic [4:0]      ID_EX_rs1_addr, ID_EX_rs2_addr, ID_EX_rd_addr;
  logic [XLEN-1:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;

  logic            EX_MEM_valid, EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemtoReg;
  logic            EX_MEM_Branch, EX_MEM_zero;
  logic [2:0]      EX_MEM_funct3;
  logic [4:0]      EX_MEM_rd_addr;
  logic [XLEN-1:0] EX_MEM_pc, EX_MEM_imm, EX_MEM_alu_result, EX_MEM_rs2_data;

  logic            MEM_WB_valid, MEM_WB_RegWrite, MEM_WB_MemtoReg;
  logic [4:0]      MEM_WB_rd_addr;
  logic [XLEN-1:0] MEM_WB_alu_result, MEM_WB_read_data;

  logic            stall_pipeline, flush_IF_ID, flush_ID_EX, branch_taken;
  logic [1:0]      forward_A, forward_B;
  logic [XLEN-1:0] alu_src1, alu_src2, alu_result, write_back_data;
  logic [XLEN-1:0] fwd_b_data, rf_rs1_data, rf_rs2_data, mem_read_data;

  logic            dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg;
  logic            dec_alu_src, dec_branch;
  logic [3:0]      dec_alu_op;
  logic [XLEN-1:0] dec_imm;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            rf_we;

  // Fixed program ROM, word-indexed by pc[7:2]
  always_comb begin
    instr_c = NOP_INSTR;
    case (pc_current[7:2])
      6'd0:    instr_c = 32'h0050_0093;
      6'd1:    instr_c = 32'h0030_0113;
      6'd2:    instr_c = 32'h0020_81B3;
      6'd3:    instr_c = 32'h0030_2023;
      6'd4:    instr_c = 32'h0000_2203;
      6'd5:    instr_c = 32'h4012_02B3;
      6'd6:    instr_c = 32'h0022_8463;
      6'd7:    instr_c = 32'h0630_0313;
      6'd8:    instr_c = 32'h0020_E3B3;
      6'd9:    instr_c = 32'h0020_F433;
      default: instr_c = NOP_INSTR;
    endcase
  end

  assign branch_taken = EX_MEM_valid && EX_MEM_Branch &&
                        ((EX_MEM_funct3 == 3'b000 &&  EX_MEM_zero) ||
                         (EX_MEM_funct3 == 3'b001 && !EX_MEM_zero));
  assign flush_IF_ID  = branch_taken;
  assign flush_ID_EX  = branch_taken;

  assign opcode = IF_ID_instr[6:0];
  assign funct3 = IF_ID_instr[14:12];
  assign id_rd  = IF_ID_instr[11:7];
  assign id_rs1 = IF_ID_instr[19:15];
  assign id_rs2 = IF_ID_instr[24:20];

  assign stall_pipeline = ID_EX_MemRead && ID_EX_rd_addr != 5'd0 &&
                          (ID_EX_rd_addr == id_rs1 || ID_EX_rd_addr == id_rs2);

  always_comb begin
    pc_next = pc_current + 32'd4;
    if (branch_taken)        pc_next = EX_MEM_pc + EX_MEM_imm;
    else if (stall_pipeline) pc_next = pc_current;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_current <= '0;
    else      pc_current <= pc_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      IF_ID_valid <= 1'b0;
      IF_ID_instr <= '0;
      IF_ID_pc    <= '0;
    end else if (flush_IF_ID) begin
      IF_ID_valid <= 1'b0;
      IF_ID_instr <= '0;
      IF_ID_pc    <= '0;
    end else if (!stall_pipeline) begin
      IF_ID_valid <= 1'b1;
      IF_ID_instr <= instr_c;
      IF_ID_pc    <= pc_current;
    end
  end

  // Decode; unsupported encodings leave every control at 0
  always_comb begin
    dec_reg_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch     = 1'b0;
    dec_alu_op     = ALU_AND;
    dec_imm        = 32'(signed'(IF_ID_instr[31:20]));
    if (IF_ID_valid) begin
      case (opcode)
        OP_R: begin
          dec_reg_write = 1'b1;
          case (funct3)
            3'b000:  dec_alu_op = IF_ID_instr[30] ? ALU_SUB : ALU_ADD;
            3'b111:  dec_alu_op = ALU_AND;
            3'b110:  dec_alu_op = ALU_OR;
            3'b010:  dec_alu_op = ALU_SLT;
            default: dec_reg_write = 1'b0;
          endcase
        end
        OP_I: begin
          dec_reg_write = 1'b1;
          dec_alu_src   = 1'b1;
          case (funct3)
            3'b000:  dec_alu_op = ALU_ADD;
            3'b111:  dec_alu_op = ALU_AND;
            3'b110:  dec_alu_op = ALU_OR;
            3'b010:  dec_alu_op = ALU_SLT;
            default: begin dec_reg_write = 1'b0; dec_alu_src = 1'b0; end
          endcase
        end
        OP_LOAD: if (funct3 == 3'b010) begin
          dec_reg_write  = 1'b1;
          dec_mem_read   = 1'b1;
          dec_mem_to_reg = 1'b1;
          dec_alu_src    = 1'b1;
          dec_alu_op     = ALU_ADD;
        end
        OP_STORE: if (funct3 == 3'b010) begin
          dec_mem_write = 1'b1;
          dec_alu_src   = 1'b1;
          dec_alu_op    = ALU_ADD;
          dec_imm       = 32'(signed'({IF_ID_instr[31:25], IF_ID_instr[11:7]}));
        end
        OP_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) begin
          dec_branch = 1'b1;
          dec_alu_op = ALU_SUB;
          dec_imm    = 32'(signed'({IF_ID_instr[31], IF_ID_instr[7],
                                    IF_ID_instr[30:25], IF_ID_instr[11:8], 1'b0}));
        end
        default: ;
      endcase
    end
  end

  regfile rf (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr   (id_rs1),
    .rs2_addr   (id_rs2),
    .wr_en      (rf_we),
    .wr_addr    (MEM_WB_rd_addr),
    .wr_data    (write_back_data),
    .rs1_data_c (rf_rs1_data),
    .rs2_data_c (rf_rs2_data)
  );

  // ID/EX: bubble on flush or load-use stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || 1'b0) begin
      ID_EX_valid <= 1'b0; ID_EX_RegWrite <= 1'b0; ID_EX_MemRead <= 1'b0;
      ID_EX_MemWrite <= 1'b0; ID_EX_MemtoReg <= 1'b0; ID_EX_ALUSrc <= 1'b0;
      ID_EX_Branch <= 1'b0; ID_EX_ALUOp <= '0; ID_EX_funct3 <= '0;
      ID_EX_rs1_addr <= '0; ID_EX_rs2_addr <= '0; ID_EX_rd_addr <= '0;
      ID_EX_pc <= '0; ID_EX_rs1_data <= '0; ID_EX_rs2_data <= '0; ID_EX_imm <= '0;
    end else if (flush_ID_EX || stall_pipeline) begin
      ID_EX_valid <= 1'b0; ID_EX_RegWrite <= 1'b0; ID_EX_MemRead <= 1'b0;
      ID_EX_MemWrite <= 1'b0; ID_EX_MemtoReg <= 1'b0; ID_EX_ALUSrc <= 1'b0;
      ID_EX_Branch <= 1'b0; ID_EX_ALUOp <= '0; ID_EX_funct3 <= '0;
      ID_EX_rs1_addr <= '0; ID_EX_rs2_addr <= '0; ID_EX_rd_addr <= '0;
      ID_EX_pc <= '0; ID_EX_rs1_data <= '0; ID_EX_rs2_data <= '0; ID_EX_imm <= '0;
    end else begin
      ID_EX_valid <= IF_ID_valid; ID_EX_RegWrite <= dec_reg_write;
      ID_EX_MemRead <= dec_mem_read; ID_EX_MemWrite <= dec_mem_write;
      ID_EX_MemtoReg <= dec_mem_to_reg; ID_EX_ALUSrc <= dec_alu_src;
      ID_EX_Branch <= dec_branch; ID_EX_ALUOp <= dec_alu_op; ID_EX_funct3 <= funct3;
      ID_EX_rs1_addr <= id_rs1; ID_EX_rs2_addr <= id_rs2; ID_EX_rd_addr <= id_rd;
      ID_EX_pc <= IF_ID_pc; ID_EX_rs1_data <= rf_rs1_data;
      ID_EX_rs2_data <= rf_rs2_data; ID_EX_imm <= dec_imm;
    end
  end

  // Forwarding: EX/MEM result wins over the WB value
  always_comb begin
    forward_A = 2'b00;
    forward_B = 2'b00;
    if (EX_MEM_RegWrite && EX_MEM_rd_addr != 5'd0 && EX_MEM_rd_addr == ID_EX_rs1_addr)
      forward_A = 2'b10;
    else if (MEM_WB_RegWrite && MEM_WB_rd_addr != 5'd0 && MEM_WB_rd_addr == ID_EX_rs1_addr)
      forward_A = 2'b01;
    if (EX_MEM_RegWrite && EX_MEM_rd_addr != 5'd0 && EX_MEM_rd_addr == ID_EX_rs2_addr)
      forward_B = 2'b10;
    else if (MEM_WB_RegWrite && MEM_WB_rd_addr != 5'd0 && MEM_WB_rd_addr == ID_EX_rs2_addr)
      forward_B = 2'b01;
  end

  always_comb begin
    case (forward_A)
      2'b10:   alu_src1 = EX_MEM_alu_result;
      2'b01:   alu_src1 = write_back_data;
      default: alu_src1 = ID_EX_rs1_data;
    endcase
    case (forward_B)
      2'b10:   fwd_b_data = EX_MEM_alu_result;
      2'b01:   fwd_b_data = write_back_data;
      default: fwd_b_data = ID_EX_rs2_data;
    endcase
    alu_src2 = ID_EX_ALUSrc ? ID_EX_imm : fwd_b_data;
  end

  always_comb begin
    case (ID_EX_ALUOp)
      ALU_AND: alu_result = alu_src1 & alu_src2;
      ALU_OR:  alu_result = alu_src1 | alu_src2;
      ALU_ADD: alu_result = alu_src1 + alu_src2;
      ALU_SUB: alu_result = alu_src1 - alu_src2;
      ALU_SLT: alu_result = 32'($signed(alu_src1) < $signed(alu_src2));
      default: alu_result = '0;
    endcase
  end

  // EX/MEM: the instruction leaving EX is squashed by a taken branch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      EX_MEM_valid <= 1'b0; EX_MEM_RegWrite <= 1'b0; EX_MEM_MemWrite <= 1'b0;
      EX_MEM_MemtoReg <= 1'b0; EX_MEM_Branch <= 1'b0; EX_MEM_zero <= 1'b0;
      EX_MEM_funct3 <= '0; EX_MEM_rd_addr <= '0; EX_MEM_pc <= '0;
      EX_MEM_imm <= '0; EX_MEM_alu_result <= '0; EX_MEM_rs2_data <= '0;
    end else if (branch_taken) begin
      EX_MEM_valid <= 1'b0; EX_MEM_RegWrite <= 1'b0; EX_MEM_MemWrite <= 1'b0;
      EX_MEM_MemtoReg <= 1'b0; EX_MEM_Branch <= 1'b0; EX_MEM_zero <= 1'b0;
      EX_MEM_funct3 <= '0; EX_MEM_rd_addr <= '0; EX_MEM_pc <= '0;
      EX_MEM_imm <= '0; EX_MEM_alu_result <= '0; EX_MEM_rs2_data <= '0;
    end else begin
      EX_MEM_valid <= ID_EX_valid; EX_MEM_RegWrite <= ID_EX_RegWrite;
      EX_MEM_MemWrite <= ID_EX_MemWrite; EX_MEM_MemtoReg <= ID_EX_MemtoReg;
      EX_MEM_Branch <= ID_EX_Branch; EX_MEM_zero <= (alu_result == '0);
      EX_MEM_funct3 <= ID_EX_funct3; EX_MEM_rd_addr <= ID_EX_rd_addr;
      EX_MEM_pc <= ID_EX_pc; EX_MEM_imm <= ID_EX_imm;
      EX_MEM_alu_result <= alu_result; EX_MEM_rs2_data <= fwd_b_data;
    end
  end

  data_mem dm (
    .clk       (clk),
    .rst       (rst),
    .word_addr (EX_MEM_alu_result[7:2]),
    .wr_en     (EX_MEM_MemWrite && EX_MEM_valid),
    .wr_data   (EX_MEM_rs2_data),
    .rd_data_c (mem_read_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEM_WB_valid <= 1'b0; MEM_WB_RegWrite <= 1'b0; MEM_WB_MemtoReg <= 1'b0;
      MEM_WB_rd_addr <= '0; MEM_WB_alu_result <= '0; MEM_WB_read_data <= '0;
    end else begin
      MEM_WB_valid <= EX_MEM_valid; MEM_WB_RegWrite <= EX_MEM_RegWrite;
      MEM_WB_MemtoReg <= EX_MEM_MemtoReg; MEM_WB_rd_addr <= EX_MEM_rd_addr;
      MEM_WB_alu_result <= EX_MEM_alu_result; MEM_WB_read_data <= mem_read_data;
    end
  end

  assign write_back_data = MEM_WB_MemtoReg ? MEM_WB_read_data : MEM_WB_alu_result;
  assign rf_we = MEM_WB_RegWrite && MEM_WB_valid && MEM_WB_rd_addr != 5'd0;
endmodule

// File: tb/tb_processor.sv
// Scoreboard bench: an instruction-level model of the fixed program predicts
// register writebacks and stores; a monitor matches them as the pipeline retires.

module tb_processor;
  logic clk;
  logic rst;

  processor dut (.clk(clk), .rst(rst));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {K_ADDI, K_ADD, K_SUB, K_OR, K_AND, K_LW, K_SW, K_BEQ} kind_t;
  typedef struct { kind_t kind; int rd; int rs1; int rs2; int imm; } op_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
  typedef struct { logic [7:0] addr; logic [31:0] data; } st_t;

  op_t         prog [10];
  wb_t         exp_wb [$];
  st_t         exp_st [$];
  logic [31:0] mregs [32];
  logic [7:0]  mmem  [256];

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;
  int stall_cnt, flush_cnt, add_seen, sub_seen;
  bit pc_pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    prog[0] = '{K_ADDI, 1, 0, 0, 5};
    prog[1] = '{K_ADDI, 2, 0, 0, 3};
    prog[2] = '{K_ADD,  3, 1, 2, 0};
    prog[3] = '{K_SW,   0, 0, 3, 0};
    prog[4] = '{K_LW,   4, 0, 0, 0};
    prog[5] = '{K_SUB,  5, 4, 1, 0};
    prog[6] = '{K_BEQ,  0, 5, 2, 8};
    prog[7] = '{K_ADDI, 6, 0, 0, 99};
    prog[8] = '{K_OR,   7, 1, 2, 0};
    prog[9] = '{K_AND,  8, 1, 2, 0};
  end

  // Sequential ISA execution of the program; fills the expectation queues
  task automatic model_run();
    int pc;
    int a;
    logic [31:0] res;
    op_t o;
    exp_wb.delete();
    exp_st.delete();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    pc = 0;
    for (int step = 0; step < 64 && pc < 40; step++) begin
      o = prog[pc / 4];
      res = '0;
      pc = pc + 4;
      case (o.kind)
        K_ADDI: res = mregs[o.rs1] + 32'(o.imm);
        K_ADD:  res = mregs[o.rs1] + mregs[o.rs2];
        K_SUB:  res = mregs[o.rs1] - mregs[o.rs2];
        K_OR:   res = mregs[o.rs1] | mregs[o.rs2];
        K_AND:  res = mregs[o.rs1] & mregs[o.rs2];
        K_LW: begin
          a = (int'(mregs[o.rs1]) + o.imm) & 252;
          res = {mmem[a+3], mmem[a+2], mmem[a+1], mmem[a]};
        end
        K_SW: begin
          a = (int'(mregs[o.rs1]) + o.imm) & 252;
          {mmem[a+3], mmem[a+2], mmem[a+1], mmem[a]} = mregs[o.rs2];
          exp_st.push_back('{8'(a), mregs[o.rs2]});
        end
        K_BEQ: if (mregs[o.rs1] == mregs[o.rs2]) pc = pc - 4 + o.imm;
        default: ;
      endcase
      if (o.kind != K_SW && o.kind != K_BEQ && o.rd != 0) begin
        mregs[o.rd] = res;
        exp_wb.push_back('{5'(o.rd), res});
      end
    end
  endtask

  // Monitor: compares retiring writes/stores and the hazard events
  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (pc_pending) begin
        check("branch_target_pc", dut.pc_current, 32'h20);
        pc_pending = 0;
      end
      if (dut.MEM_WB_valid && dut.MEM_WB_RegWrite && dut.MEM_WB_rd_addr != 5'd0) begin
        if (exp_wb.size() == 0) begin
          check("unexpected_wb_rd", 32'(dut.MEM_WB_rd_addr), 32'hFFFF_FFFF);
        end else begin
          wb_t e;
          e = exp_wb.pop_front();
          check("wb_rd", 32'(dut.MEM_WB_rd_addr), 32'(e.rd));
          check("wb_data", dut.write_back_data, e.data);
        end
      end
      if (dut.EX_MEM_valid && dut.EX_MEM_MemWrite) begin
        if (exp_st.size() == 0) begin
          check("unexpected_store", dut.EX_MEM_alu_result, 32'hFFFF_FFFF);
        end else begin
          st_t s;
          s = exp_st.pop_front();
          check("st_addr", 32'(dut.EX_MEM_alu_result[7:0]), 32'(s.addr));
          check("st_data", dut.EX_MEM_rs2_data, s.data);
        end
      end
      if (dut.stall_pipeline) begin
        stall_cnt++;
        check("stall_ifid_pc", dut.IF_ID_pc, 32'h14);
      end
      if (dut.flush_IF_ID) begin
        flush_cnt++;
        check("flush_id_ex", 32'(dut.flush_ID_EX), 32'd1);
        pc_pending = 1;
      end
      if (dut.ID_EX_valid && dut.ID_EX_pc == 32'h08) begin
        add_seen++;
        check("add_fwd_a", 32'(dut.forward_A), 32'd1);
        check("add_fwd_b", 32'(dut.forward_B), 32'd2);
        check("add_result", dut.alu_result, 32'd8);
      end
      if (dut.ID_EX_valid && dut.ID_EX_pc == 32'h14) begin
        sub_seen++;
        check("sub_fwd_a", 32'(dut.forward_A), 32'd1);
        check("sub_src1", dut.alu_src1, 32'd8);
        check("sub_result", dut.alu_result, 32'd3);
      end
    end
  end

  task automatic check_cleared(input string tag);
    int nz;
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.rf.registers[i] != 32'd0) nz++;
    check({tag, "_pc"}, dut.pc_current, 32'd0);
    check({tag, "_valids"}, 32'({dut.IF_ID_valid, dut.ID_EX_valid,
                                dut.EX_MEM_valid, dut.MEM_WB_valid}), 32'd0);
    check({tag, "_nonzero_regs"}, 32'(nz), 32'd0);
    check({tag, "_mem_word0"}, {dut.dm.mem[3], dut.dm.mem[2], dut.dm.mem[1], dut.dm.mem[0]}, 32'd0);
  endtask

  task automatic start_run();
    model_run();
    stall_cnt = 0; flush_cnt = 0; add_seen = 0; sub_seen = 0; pc_pending = 0;
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1;
  endtask

  logic [31:0] spec_regs [9];
  logic [31:0] mword;

  initial begin
    spec_regs = '{32'd0, 32'd5, 32'd3, 32'd8, 32'd8, 32'd3, 32'd0, 32'd7, 32'd1};
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 check_cleared("por");

    // Abort the program at a random point with an asynchronous reset
    for (int it = 0; it < 3; it++) begin
      int n;
      n = int'($urandom_range(4, 18));
      start_run();
      repeat (n) @(posedge clk);
      #($urandom_range(1, 4));
      mon_en = 0;
      rst = 1'b0;
      #1 check_cleared($sformatf("abort%0d", it));
    end

    start_run();
    repeat (25) @(posedge clk);
    @(negedge clk);
    mon_en = 0;

    for (int i = 1; i < 32; i++)
      check($sformatf("model_x%0d", i), dut.rf.registers[i], mregs[i]);
    for (int i = 1; i < 9; i++)
      check($sformatf("final_x%0d", i), dut.rf.registers[i], spec_regs[i]);
    for (int i = 0; i < 4; i++)
      check($sformatf("mem%0d", i), 32'(dut.dm.mem[i]), 32'(mmem[i]));
    mword = {dut.dm.mem[3], dut.dm.mem[2], dut.dm.mem[1], dut.dm.mem[0]};
    check("mem_word0", mword, 32'h0000_0008);
    check("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
    check("st_queue_drained", 32'(exp_st.size()), 32'd0);
    check("stall_cycles", 32'(stall_cnt), 32'd1);
    check("flush_cycles", 32'(flush_cnt), 32'd1);
    check("add_in_ex", 32'(add_seen), 32'd1);
    check("sub_in_ex", 32'(sub_seen), 32'd1);

    // Reset mid-run after completion as well
    #2 rst = 1'b0;
    #1 check_cleared("late");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous and active-low.
REQ-003 No other ports; state is observed hierarchically.
- Hierarchical signals: pc_current, IF_ID_*, ID_EX_*, EX_MEM_*, MEM_WB_* (each stage has a _valid bit), stall_pipeline, flush_IF_ID, flush_ID_EX, forward_A/forward_B (2b), alu_src1, alu_src2, alu_result, write_back_data.
- Instances: rf.registers[0:31] (32b) and dm.mem[] (8b bytes).

Function
REQ-004 The design SHALL be a 5-stage RV32I subset pipeline: IF, ID, EX, MEM, WB.
REQ-005 Supported instructions SHALL be: add, sub, and, or, slt; addi, andi, ori, slti; lw, sw; beq, bne. Any other opcode SHALL execute as a NOP.
REQ-006 Instruction memory SHALL be a word-indexed ROM (64 words, addressed by PC[7:2]) holding the fixed program listed below; all unlisted words SHALL read 0x00000013 (NOP).
- 0x00 addi x1,x0,5
- 0x04 addi x2,x0,3
- 0x08 add x3,x1,x2
- 0x0C sw x3,0(x0)
- 0x10 lw x4,0(x0)
- 0x14 sub x5,x4,x1
- 0x18 beq x5,x2,+8
- 0x1C addi x6,x0,99
- 0x20 or x7,x1,x2
- 0x24 and x8,x1,x2
REQ-007 Data memory SHALL be 256 bytes, byte-addressed, little-endian, with 32-bit word access only; it SHALL write synchronously and read combinationally.
REQ-008 The register file SHALL have 32x32 entries; x0 SHALL read 0 and ignore writes.
REQ-009 A register file write in WB SHALL be visible to an ID read in the same cycle (internal write-through bypass).
REQ-010 ID_EX_ALUOp SHALL be 4 bits: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed).
REQ-011 lw/sw SHALL use ADD; beq/bne SHALL use SUB, with zero = (result==0).
REQ-012 Immediates SHALL be sign-extended: I-type for ALU and lw, S-type for sw, B-type for branches.
REQ-013 forward_A/forward_B SHALL be: 10 = EX_MEM_alu_result when EX_MEM_RegWrite, EX_MEM rd≠0 and rd==rs; else 01 = write_back_data under the same condition on MEM_WB; else 00. EX/MEM SHALL have priority.
REQ-014 Load-use: when ID_EX_MemRead and ID_EX_rd_addr≠0 and it equals IF/ID rs1 or rs2, stall_pipeline SHALL be 1 for one cycle.
REQ-015 During a stall, PC and IF/ID SHALL hold, and ID/EX SHALL load a bubble (all control 0, valid 0).
REQ-016 Branches SHALL resolve in MEM from EX_MEM_Branch, EX_MEM_zero and funct3 (beq taken on zero, bne on !zero).
REQ-017 A taken branch SHALL set PC to EX_MEM_pc+imm and assert flush_IF_ID and flush_ID_EX in that cycle. Both registers, and EX/MEM's incoming instruction, SHALL become bubbles, for a 3-cycle penalty.
REQ-018 A flush SHALL take priority over a simultaneous stall.
REQ-019 Not-taken branches SHALL incur no penalty; PC SHALL otherwise increment by 4 each unstalled cycle.
REQ-020 WB SHALL write write_back_data (MemtoReg ? MEM_WB_read_data : MEM_WB_alu_result) only when MEM_WB_RegWrite, MEM_WB_valid and rd≠0.
REQ-021 sw SHALL write memory only when EX_MEM_MemWrite and EX_MEM_valid.

Reset
REQ-022 When rst is low, the design SHALL asynchronously set: PC=0; all pipeline registers, controls and valid bits 0; all 32 registers 0; all data memory 0.
REQ-023 Fetch of 0x00 SHALL occur on the first rising edge after rst goes high.
REQ-024 Reset asserted mid-program SHALL abandon all in-flight instructions and restart at PC 0.

Verification
REQ-025 Release reset and run 25 cycles. Required final state:
- x1=5, x2=3, x3=8, x4=8, x5=3, x6=0, x7=7, x8=1
- mem[0..3]=08,00,00,00
REQ-026 add x3 at 0x08 SHALL show forward_A=01 (x1) and forward_B=10 (x2), with alu_result 8.
REQ-027 sub at 0x14 SHALL cause exactly one cycle with stall_pipeline=1 while IF/ID holds 0x14. The sub SHALL then execute with forward_A=01 selecting the loaded value 8, giving result 3.
REQ-028 beq at 0x18 SHALL cause exactly one cycle with flush_IF_ID=flush_ID_EX=1 and next PC 0x20; x6 SHALL never be written.
REQ-029 Asserting rst low mid-run SHALL immediately return pc_current to 0 and clear all _valid bits and registers.
